// File: rtl/hex2ascii_stream_if.sv
// hex2ascii_stream_if
//   Word-in / character-out handshake bundle for hex2ascii_stream.
//   master : word producer and character sink (drives in_*, lower, out_ready)
//   slave  : the serializer (drives in_ready, out_valid, out_char, out_last)
//   Signals:
//     in_valid, in_ready, in_data[WIDTH], lower          word handshake
//     out_valid, out_ready, out_char[7], out_last        character handshake
interface hex2ascii_stream_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             lower;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_char;
  logic             out_last;

  modport master (
    output in_valid, in_data, lower, out_ready,
    input  in_ready, out_valid, out_char, out_last
  );

  modport slave (
    input  in_valid, in_data, lower, out_ready,
    output in_ready, out_valid, out_char, out_last
  );
endinterface

// File: rtl/hex2ascii_stream.sv
// hex2ascii_stream
//   Accepts one WIDTH-bit word and streams its hex representation as 7-bit
//   ASCII, most-significant nibble first, with optional "0x" prefix and
//   optional CR LF terminator.
//   Ports:
//     clk   clock, rising edge
//     rst   synchronous active-high reset
//     bus   hex2ascii_stream_if.slave (word in, characters out)
//     busy  high while a word is being emitted
//
//   state | meaning
//   IDLE  | waiting for a word, in_ready high
//   PFX0  | presenting '0'
//   PFX1  | presenting 'x'
//   DIGIT | presenting top nibble of the shift register
//   CR    | presenting carriage return
//   LF    | presenting line feed (last character)
module hex2ascii_stream #(
  parameter int WIDTH   = 16,
  parameter int PREFIX  = 0,
  parameter int NEWLINE = 0
) (
  input  logic                clk,
  input  logic                rst,
  hex2ascii_stream_if.slave   bus,
  output logic                busy
);
  localparam int NDIG = WIDTH / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("hex2ascii_stream: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, CR, LF} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic             lower_q;
  logic [CW-1:0]    cnt;

  function automatic logic [6:0] hex_char(input logic [3:0] n, input logic low);
    if (n < 4'd10)
      return 7'h30 + 7'(n);
    else
      return (low ? 7'h61 : 7'h41) + 7'(n) - 7'd10;
  endfunction

  assign sh_next    = sh << 4;
  assign bus.in_ready = (state == IDLE) && !rst;

  // Only one digit and no terminator: the first digit is also the last char.
  localparam bit SINGLE_LAST = (NDIG == 1) && (NEWLINE == 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sh            <= '0;
      lower_q       <= 1'b0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_char  <= 7'h00;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh            <= bus.in_data;
            lower_q       <= bus.lower;
            cnt           <= CW'(NDIG - 1);
            bus.out_valid <= 1'b1;
            busy          <= 1'b1;
            if (PREFIX != 0) begin
              state        <= PFX0;
              bus.out_char <= 7'h30;
              bus.out_last <= 1'b0;
            end else begin
              state        <= DIGIT;
              bus.out_char <= hex_char(bus.in_data[WIDTH-1 -: 4], bus.lower);
              bus.out_last <= SINGLE_LAST;
            end
          end
        end
        PFX0: begin
          if (bus.out_ready) begin
            state        <= PFX1;
            bus.out_char <= 7'h78;
          end
        end
        PFX1: begin
          if (bus.out_ready) begin
            state        <= DIGIT;
            bus.out_char <= hex_char(sh[WIDTH-1 -: 4], lower_q);
            bus.out_last <= SINGLE_LAST;
          end
        end
        DIGIT: begin
          if (bus.out_ready) begin
            if (cnt == '0) begin
              if (NEWLINE != 0) begin
                state        <= CR;
                bus.out_char <= 7'h0D;
                bus.out_last <= 1'b0;
              end else begin
                state         <= IDLE;
                bus.out_valid <= 1'b0;
                bus.out_char  <= 7'h00;
                bus.out_last  <= 1'b0;
                busy          <= 1'b0;
              end
            end else begin
              sh           <= sh_next;
              cnt          <= cnt - 1'b1;
              bus.out_char <= hex_char(sh_next[WIDTH-1 -: 4], lower_q);
              // Moving onto the final digit.
              bus.out_last <= (cnt == CW'(1)) && (NEWLINE == 0);
            end
          end
        end
        CR: begin
          if (bus.out_ready) begin
            state        <= LF;
            bus.out_char <= 7'h0A;
            bus.out_last <= 1'b1;
          end
        end
        LF: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_char  <= 7'h00;
            bus.out_last  <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.out_char  <= 7'h00;
          bus.out_last  <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end
endmodule
